// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end. Issues in-order word fetches to
// imem under a credit limit, buffers returned words with their PCs, and
// presents one registered instruction per cycle to decode. Redirects from
// execute flush buffered work and drop responses still in flight.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BUF_DEPTH       = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr,
  output logic        kill_instr,
  output logic [31:0] current_program_counter,
  output logic [31:0] next_program_counter
);

  localparam int                PTR_W     = $clog2(BUF_DEPTH);
  localparam int                CNT_W     = 5;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0]  MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [31:0]       NOP       = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic [CNT_W-1:0] buf_count_q, buf_count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      instr_q, instr_d;
  logic             kill_q, kill_d;
  logic [31:0]      cur_pc_q, cur_pc_d;

  logic [31:0]      buf_data_q [BUF_DEPTH];
  logic [31:0]      buf_pc_q   [BUF_DEPTH];

  logic [CNT_W-1:0] credits_used;
  logic [CNT_W-1:0] outstanding_after_resp;
  logic [31:0]      redirect_target;
  logic             req_fire;
  logic             resp_live;
  logic             push;
  logic             pop;

  // Request side: a slot is granted only if the word it returns is sure to
  // find room, counting live in-flight words plus those already buffered.
  always_comb begin
    credits_used   = outstanding_q - drop_count_q + buf_count_q;
    imem_req_valid = !redirect_valid && (outstanding_q < MAX_OUT_C) &&
                     (credits_used < DEPTH_C);
    imem_req_addr  = fetch_pc_q;
  end

  // Next-state for counters, buffer pointers and the decode-facing register.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_count_d  = drop_count_q;
    buf_count_d   = buf_count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    instr_d       = instr_q;
    kill_d        = kill_q;
    cur_pc_d      = cur_pc_q;
    push          = 1'b0;
    pop           = 1'b0;

    redirect_target        = redirect_pc & 32'hFFFF_FFFC;
    req_fire               = imem_req_valid && imem_req_ready;
    resp_live              = imem_resp_valid && (drop_count_q == '0) && !redirect_valid;
    outstanding_after_resp = outstanding_q - CNT_W'(imem_resp_valid);
    outstanding_d          = outstanding_after_resp + CNT_W'(req_fire);

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (imem_resp_valid && (drop_count_q != '0)) drop_count_d = drop_count_q - CNT_W'(1);
    if (resp_live) resp_pc_d = resp_pc_q + 32'd4;

    if (redirect_valid) begin
      // Everything still in flight belongs to the wrong path.
      instr_d      = NOP;
      kill_d       = 1'b1;
      fetch_pc_d   = redirect_target;
      resp_pc_d    = redirect_target;
      drop_count_d = outstanding_after_resp;
      buf_count_d  = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
    end else begin
      if (!stall) begin
        if (buf_count_q != '0) begin
          pop      = 1'b1;
          instr_d  = buf_data_q[rd_ptr_q];
          kill_d   = 1'b0;
          cur_pc_d = buf_pc_q[rd_ptr_q];
        end else if (resp_live) begin
          // Empty buffer: the arriving word goes straight into the output
          // register, so decode sees it the next cycle.
          instr_d  = imem_resp_data;
          kill_d   = 1'b0;
          cur_pc_d = resp_pc_q;
        end else begin
          instr_d  = NOP;
          kill_d   = 1'b1;
        end
      end
      push = resp_live && (stall || (buf_count_q != '0));
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      buf_count_d = buf_count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_count_q  <= '0;
      buf_count_q   <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      instr_q       <= NOP;
      kill_q        <= 1'b1;
      cur_pc_q      <= 32'h0000_0000;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      buf_count_q   <= buf_count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_q       <= instr_d;
      kill_q        <= kill_d;
      cur_pc_q      <= cur_pc_d;
    end
  end

  // Buffer storage; contents are qualified by buf_count so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= imem_resp_data;
      buf_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign instr                   = instr_q;
  assign kill_instr              = kill_q;
  assign current_program_counter = cur_pc_q;
  assign next_program_counter    = cur_pc_q + 32'd4;

  // A push into a full buffer means the credit accounting is broken.
  buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                    !(push && (buf_count_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: drives fetch_stage with a latency-programmable imem and
// compares every cycle against a queue-based model of the fetch stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC        = 32'hFFFF_FFF8;
  localparam int          BUF_DEPTH       = 2;
  localparam int          MAX_OUTSTANDING = 2;
  localparam logic [31:0] NOP             = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] instr;
  logic        kill_instr;
  logic [31:0] current_program_counter;
  logic [31:0] next_program_counter;

  fetch_stage #(
    .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instr(instr), .kill_instr(kill_instr),
    .current_program_counter(current_program_counter),
    .next_program_counter(next_program_counter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  // Model state: requests in flight (tagged with the path epoch they were
  // issued on) and live words returned but not yet shown to decode.
  req_t        infl[$];
  logic [31:0] retq[$];
  int          epoch;
  int          cyc;
  int          checks;
  int          failures;
  logic [31:0] exp_fetch;
  logic [31:0] exp_instr;
  logic [31:0] exp_cur;
  logic        exp_kill;
  logic        pc_known;
  logic [31:0] first_live_pc;
  bit          first_seen;
  bit          logging;
  logic [31:0] log_pc[$];
  logic [31:0] log_next[$];
  int          log_cyc[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    retq.delete();
    epoch++;
    exp_fetch  = RESET_PC;
    exp_instr  = NOP;
    exp_kill   = 1'b1;
    exp_cur    = 32'h0;
    pc_known   = 1'b1;
    first_seen = 1'b0;
    cyc        = 0;
  endtask

  // Asynchronous reset applied between clock edges; imem is reset with it.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    chk("rst_instr", instr, NOP);
    chk("rst_kill", kill_instr, 1'b1);
    chk("rst_cur_pc", current_program_counter, 32'h0);
    chk("rst_next_pc", next_program_counter, 32'h4);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: check outputs of the last edge, drive inputs, check the
  // request side, then advance the model across the coming edge.
  task automatic step(input bit s, input bit r, input logic [31:0] rpc,
                      input bit rdy, input int lat);
    bit          rv;
    bit          exp_rq;
    int          live_cnt;
    req_t        e;
    logic [31:0] p;
    @(negedge clk);
    chk("instr", instr, exp_instr);
    chk("kill", kill_instr, exp_kill);
    if (pc_known) begin
      chk("cur_pc", current_program_counter, exp_cur);
      chk("next_pc", next_program_counter, exp_cur + 32'd4);
    end
    if (!exp_kill) begin
      if (!first_seen) begin
        first_seen    = 1'b1;
        first_live_pc = current_program_counter;
      end
      if (logging) begin
        log_pc.push_back(current_program_counter);
        log_next.push_back(next_program_counter);
        log_cyc.push_back(cyc);
      end
    end
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    rv = (infl.size() > 0) && (infl[0].due <= cyc);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? word_of(infl[0].addr) : $urandom;
    #1;
    live_cnt = 0;
    foreach (infl[i]) if (infl[i].ep == epoch) live_cnt++;
    exp_rq = !r && (infl.size() < MAX_OUTSTANDING) &&
             (live_cnt + retq.size() < BUF_DEPTH);
    chk("req_valid", imem_req_valid, exp_rq);
    if (exp_rq) chk("req_addr", imem_req_addr, exp_fetch);
    if (rv) begin
      e = infl.pop_front();
      if (e.ep == epoch && !r) retq.push_back(e.addr);
    end
    if (exp_rq && rdy) begin
      e.addr = exp_fetch;
      e.ep   = epoch;
      e.due  = cyc + lat;
      infl.push_back(e);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (r) begin
      epoch++;
      retq.delete();
      exp_fetch  = {rpc[31:2], 2'b00};
      exp_instr  = NOP;
      exp_kill   = 1'b1;
      pc_known   = 1'b0;
      first_seen = 1'b0;
    end else if (!s) begin
      if (retq.size() > 0) begin
        p         = retq.pop_front();
        exp_instr = word_of(p);
        exp_kill  = 1'b0;
        exp_cur   = p;
        pc_known  = 1'b1;
      end else begin
        exp_instr = NOP;
        exp_kill  = 1'b1;
      end
    end
    cyc++;
  endtask

  // Stimulus, directed scenarios first, then a randomized stream.
  initial begin
    checks   = 0;
    failures = 0;
    epoch    = 0;
    logging  = 1'b1;
    do_reset();

    // Streaming from RESET_PC across the 32-bit wrap, 1-cycle imem.
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    logging = 1'b0;
    chk("wrap_pc0", log_pc[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", log_pc[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", log_pc[2], 32'h0000_0000);
    chk("wrap_next1", log_next[1], 32'h0000_0000);
    chk("first_live_cycle", log_cyc[0], 2);

    // Redirect to 0, stream, then hold stall for three cycles mid-stream.
    step(1'b0, 1'b1, 32'h0, 1'b1, 1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("first_after_0", first_live_pc, 32'h0);

    // Redirect to 0x100 with two requests in flight.
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 2);
    step(1'b0, 1'b1, 32'h100, 1'b1, 2);
    @(posedge clk);
    #1;
    chk("redir_nop", instr, NOP);
    chk("redir_kill", kill_instr, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 2);
    chk("first_after_100", first_live_pc, 32'h100);

    // Redirect while stalled, with a misaligned target.
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
    step(1'b1, 1'b1, 32'h102, 1'b1, 1);
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("first_after_stalled_redir", first_live_pc, 32'h100);

    // Two redirects close together with 3-cycle imem latency.
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 3);
    step(1'b0, 1'b1, 32'h200, 1'b1, 3);
    step(1'b0, 1'b0, 32'h0, 1'b1, 3);
    step(1'b0, 1'b1, 32'h300, 1'b1, 3);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 3);
    chk("first_after_300", first_live_pc, 32'h300);

    // Randomized traffic, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      bit          s;
      bit          r;
      bit          rdy;
      logic [31:0] t;
      s   = ($urandom_range(0, 99) < 25);
      r   = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else                           t = $urandom & 32'h0000_FFFF;
      step(s, r, t, rdy, $urandom_range(1, 4));
      if (i == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Front end of the 5-stage RISC-V pipeline, feeding the decode stage. It generates the sequential fetch PC and issues in-order requests to instruction memory. Returned words are buffered with their PCs and presented to decode as instr, kill_instr, current_program_counter and next_program_counter. On a taken-branch or JALR redirect from execute, it flushes wrong-path work and injects killed NOPs.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
BUF_DEPTH, 2, instruction buffer entries (instr+PC); power of two, 2..8.
MAX_OUTSTANDING, 2, maximum imem requests in flight; 1..BUF_DEPTH.

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  decode cannot accept; hold outputs.
redirect_valid  in  1  taken branch/JALR resolved this cycle.
redirect_pc  in  32  new fetch target; bits[1:0] ignored and forced to 0.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  imem accepts request.
imem_req_addr  out  32  word-aligned fetch address.
imem_resp_valid  in  1  in-order response valid (≥1 cycle after acceptance).
imem_resp_data  in  32  instruction word.
instr  out  32  instruction to decode (registered).
kill_instr  out  1  decode must treat instr as NOP.
current_program_counter  out  32  PC of instr.
next_program_counter  out  32  current_program_counter+4, modulo 2^32.

Behaviour:
- Reset, asynchronous:
  - fetch_pc=RESET_PC; buffer empty; outstanding=0; drop_count=0.
  - instr=32'h0000_0013 (NOP); kill_instr=1; current_program_counter=0; next_program_counter=4.
- Request issue (combinational from registered state):
  - imem_req_valid = !redirect_valid && outstanding<MAX_OUTSTANDING && (outstanding-drop_count+buf_count)<BUF_DEPTH.
  - imem_req_addr=fetch_pc.
  - On accept (valid&&ready): fetch_pc+=4 (wraps 32'hFFFF_FFFC→0); outstanding+=1.
- Response handling, every cycle with imem_resp_valid:
  - outstanding-=1.
  - If drop_count>0 (or redirect_valid this cycle): discard the word; drop_count-=1 if nonzero.
  - Otherwise push {data, pc} into the buffer. The PC comes from a resp_pc register that starts at fetch_pc on redirect/reset and increments by 4 per live response.
  - The credit rule guarantees the buffer never overflows. A push to a full buffer is a design error; flag it with a simulation assertion.
- Output register update, priority order:
  1. redirect_valid: load NOP, kill=1. Flush the buffer. fetch_pc=resp_pc=redirect_pc&~3. drop_count = outstanding after this cycle's response. Overrides stall.
  2. stall: all outputs hold.
  3. Buffer non-empty: pop head. instr=data, kill=0, PCs from the entry.
  4. Buffer empty: instr=NOP, kill=1. PCs hold their previous values.
- Same-cycle push and pop are allowed. A word arriving into an empty buffer is visible at the outputs one cycle later, so decode is never fed combinationally from imem.
- Latency: request accept → response cycle R → instr at outputs at R+1 (when not stalled).
- Simultaneous redirect + request-ready: no request issues that cycle. The first request to redirect_pc issues the next cycle.
- Back-to-back redirects: drop_count is re-computed each time and never underflows. The flushed buffer stays empty.
- Reset mid-transaction: in-flight imem responses arriving after reset deassertion are not tracked. Environment contract: imem is reset together with this block.

Test Plan:
- Reset, then imem with 1-cycle latency and always ready, no stall → instr/PC sequence 0x0,0x4,0x8… with kill_instr=0 from cycle 3. next_program_counter = PC+4.
- stall high for 3 cycles mid-stream with BUF_DEPTH=2 → outputs frozen at PC 0x8. Buffer fills to 2. imem_req_valid drops. Stream resumes at 0xC with no loss or duplication.
- redirect_valid, redirect_pc=0x100, with 2 requests outstanding (PCs 0x10,0x14) → both responses discarded. Next cycle kill_instr=1, instr=0x00000013. First live instr has PC 0x100.
- redirect while stall=1 → outputs become NOP/kill=1 anyway. After stall release, PC 0x100 arrives.
- Two redirects 1 cycle apart (0x200, then 0x300) with 3-cycle imem latency → no 0x200 instruction is ever presented. First instr PC = 0x300.
- RESET_PC=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. next_program_counter of FFFF_FFFC = 0.
